// File: rtl/crc8_frame_tx.sv
// Byte-stream framer: forwards data bytes and appends a CRC-8 (poly 0x07) byte
// after each frame, force-closing frames that reach MAX_LEN bytes.
module crc8_frame_tx #(
  parameter logic [7:0]  CRC_INIT = 8'h00,
  parameter int unsigned MAX_LEN  = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  output logic [7:0]  m_data,
  output logic        m_valid,
  output logic        m_last,
  input  logic        m_ready,
  output logic        len_err,
  output logic [15:0] frame_cnt
);

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 16;
  localparam logic [CW-1:0] LEN_LIMIT = CW'(MAX_LEN);

  typedef enum logic {
    ST_DATA,
    ST_CRC_PEND
  } state_t;

  state_t          state, state_d;
  logic [DW-1:0]   crc, crc_d;
  logic [CW-1:0]   byte_cnt, byte_cnt_d;
  logic [DW-1:0]   m_data_d;
  logic            m_valid_d, m_last_d, len_err_d;
  logic [CW-1:0]   frame_cnt_d;
  logic            slot_free, take_in, take_out;

  // One CRC-8 step over a whole byte, MSB first.
  function automatic logic [DW-1:0] crc8_next(input logic [DW-1:0] c, input logic [DW-1:0] d);
    logic [DW-1:0] r;
    r = c ^ d;
    for (int i = 0; i < 8; i++) begin
      r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
    end
    return r;
  endfunction

  assign slot_free = !m_valid || m_ready;
  assign s_ready   = (state == ST_DATA) && slot_free && !rst;
  assign take_in   = s_valid && s_ready;
  assign take_out  = m_valid && m_ready;

  // Next-state and datapath decisions.
  always_comb begin
    state_d     = state;
    crc_d       = crc;
    byte_cnt_d  = byte_cnt;
    m_data_d    = m_data;
    m_valid_d   = m_valid;
    m_last_d    = m_last;
    len_err_d   = 1'b0;
    frame_cnt_d = frame_cnt;

    if (take_out && m_last) begin
      frame_cnt_d = frame_cnt + 16'd1;
    end

    case (state)
      ST_DATA: begin
        if (take_in) begin
          m_data_d   = s_data;
          m_valid_d  = 1'b1;
          m_last_d   = 1'b0;
          crc_d      = crc8_next(crc, s_data);
          byte_cnt_d = byte_cnt + 16'd1;
          if (s_last) begin
            state_d = ST_CRC_PEND;
          end else if (byte_cnt_d == LEN_LIMIT) begin
            state_d   = ST_CRC_PEND;
            len_err_d = 1'b1;
          end
        end else if (take_out) begin
          m_valid_d = 1'b0;
          m_last_d  = 1'b0;
        end
      end
      ST_CRC_PEND: begin
        // The previous byte may hand off in this same cycle; the CRC replaces it.
        if (slot_free) begin
          m_data_d   = crc;
          m_valid_d  = 1'b1;
          m_last_d   = 1'b1;
          crc_d      = CRC_INIT;
          byte_cnt_d = '0;
          state_d    = ST_DATA;
        end
      end
      default: state_d = ST_DATA;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_DATA;
      crc       <= CRC_INIT;
      byte_cnt  <= '0;
      m_data    <= '0;
      m_valid   <= 1'b0;
      m_last    <= 1'b0;
      len_err   <= 1'b0;
      frame_cnt <= '0;
    end else begin
      state     <= state_d;
      crc       <= crc_d;
      byte_cnt  <= byte_cnt_d;
      m_data    <= m_data_d;
      m_valid   <= m_valid_d;
      m_last    <= m_last_d;
      len_err   <= len_err_d;
      frame_cnt <= frame_cnt_d;
    end
  end

endmodule
